// File: rtl/class_accumulator_if.sv
// Bus bundle between the class accumulator and its controller: training,
// clear/binarize commands, and the counter-chunk readout stream.
interface class_accumulator_if #(
    parameter int DIMS_PER_CC      = 32,
    parameter int BITWIDTH_PER_DIM = 4,
    parameter int NUM_CC           = 16,
    parameter int NUM_CLASSES      = 4
);
    localparam int CCW = $clog2(NUM_CC);
    localparam int CLW = $clog2(NUM_CLASSES);
    localparam int WW  = DIMS_PER_CC * BITWIDTH_PER_DIM;

    logic                   en;
    logic                   clr_start;
    logic                   train_valid;
    logic                   train_ready;
    logic [CLW-1:0]         train_class;
    logic [CCW-1:0]         train_cc;
    logic [DIMS_PER_CC-1:0] train_hv;
    logic                   bin_start;
    logic [CLW-1:0]         bin_class;
    logic                   busy;
    logic                   binarizing_class_hvs;
    logic [CCW-1:0]         bin_cc;
    logic [WW-1:0]          nonbin_class_reg_out;
    logic                   bin_done;

    modport master (
        output en, clr_start, train_valid, train_class, train_cc, train_hv,
               bin_start, bin_class,
        input  train_ready, busy, binarizing_class_hvs, bin_cc,
               nonbin_class_reg_out, bin_done
    );

    modport slave (
        input  en, clr_start, train_valid, train_class, train_cc, train_hv,
               bin_start, bin_class,
        output train_ready, busy, binarizing_class_hvs, bin_cc,
               nonbin_class_reg_out, bin_done
    );
endinterface

// File: rtl/class_accumulator.sv
// Per-class, per-chunk saturating counter file: accumulates binary training chunks,
// streams one class chunk-by-chunk to the thresholder, and clears itself on request.
module class_accumulator #(
    parameter int DIMS_PER_CC      = 32,
    parameter int BITWIDTH_PER_DIM = 4,
    parameter int NUM_CC           = 16,
    parameter int NUM_CLASSES      = 4
) (
    input  logic               clk,
    input  logic               nrst,
    class_accumulator_if.slave bus
);
    localparam int CCW = $clog2(NUM_CC);
    localparam int CLW = $clog2(NUM_CLASSES);
    localparam int BW  = BITWIDTH_PER_DIM;
    localparam int WW  = DIMS_PER_CC * BW;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BINARIZE, S_DONE} state_t;

    state_t         state_reg, state_next;
    logic [CCW-1:0] bin_cc_reg, bin_cc_next;
    logic [CLW-1:0] bin_class_reg, bin_class_next;
    logic [CCW-1:0] clr_cc_reg, clr_cc_next;
    logic [CLW-1:0] clr_class_reg, clr_class_next;
    logic [WW-1:0]  out_reg, out_next;
    logic           valid_reg, valid_next;
    logic           done_reg, done_next;
    logic           train_we, clr_we, train_ready;

    logic [WW-1:0]  ctr_reg [NUM_CLASSES][NUM_CC];

    // Single readout port: IDLE prefetches chunk 0 of the requested class,
    // BINARIZE prefetches the chunk after the one currently presented.
    logic [CLW-1:0] rd_class;
    logic [CCW-1:0] rd_cc;
    logic [WW-1:0]  rd_word;
    logic           rd_ok;
    assign rd_class = (state_reg == S_IDLE) ? bus.bin_class : bin_class_reg;
    assign rd_cc    = (state_reg == S_IDLE) ? '0 : bin_cc_reg + CCW'(1);
    assign rd_ok    = int'(rd_class) < NUM_CLASSES;
    assign rd_word  = rd_ok ? ctr_reg[rd_class][rd_cc] : '0;

    logic [WW-1:0] train_word, train_sum;
    logic          train_in_range;
    assign train_in_range = (int'(bus.train_cc) < NUM_CC) && (int'(bus.train_class) < NUM_CLASSES);
    assign train_word     = train_in_range ? ctr_reg[bus.train_class][bus.train_cc] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DIMS_PER_CC; gi++) begin : g_dim
            logic [BW-1:0] cur;
            assign cur = train_word[gi*BW +: BW];
            assign train_sum[gi*BW +: BW] = (bus.train_hv[gi] && (cur != '1)) ? cur + BW'(1) : cur;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        bin_cc_next    = bin_cc_reg;
        bin_class_next = bin_class_reg;
        clr_cc_next    = clr_cc_reg;
        clr_class_next = clr_class_reg;
        out_next       = out_reg;
        valid_next     = valid_reg;
        done_next      = done_reg;
        train_we       = 1'b0;
        clr_we         = 1'b0;
        train_ready    = 1'b0;
        if (bus.en) begin
            out_next   = '0;
            valid_next = 1'b0;
            done_next  = 1'b0;
            case (state_reg)
                S_IDLE: begin
                    train_ready = nrst & ~bus.clr_start & ~bus.bin_start;
                    if (bus.clr_start) begin
                        state_next     = S_CLEAR;
                        clr_cc_next    = '0;
                        clr_class_next = '0;
                    end else if (bus.bin_start) begin
                        state_next     = S_BINARIZE;
                        bin_class_next = bus.bin_class;
                        bin_cc_next    = '0;
                        valid_next     = 1'b1;
                        out_next       = rd_word;
                    end else if (bus.train_valid) begin
                        train_we = train_in_range;
                    end
                end
                S_CLEAR: begin
                    clr_we = 1'b1;
                    if (clr_cc_reg == CCW'(NUM_CC - 1)) begin
                        clr_cc_next = '0;
                        if (clr_class_reg == CLW'(NUM_CLASSES - 1)) state_next = S_IDLE;
                        else clr_class_next = clr_class_reg + CLW'(1);
                    end else begin
                        clr_cc_next = clr_cc_reg + CCW'(1);
                    end
                end
                S_BINARIZE: begin
                    if (bin_cc_reg == CCW'(NUM_CC - 1)) begin
                        state_next  = S_DONE;
                        done_next   = 1'b1;
                        bin_cc_next = '0;
                    end else begin
                        bin_cc_next = bin_cc_reg + CCW'(1);
                        valid_next  = 1'b1;
                        out_next    = rd_word;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= S_IDLE;
            bin_cc_reg    <= '0;
            bin_class_reg <= '0;
            clr_cc_reg    <= '0;
            clr_class_reg <= '0;
            out_reg       <= '0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bin_cc_reg    <= bin_cc_next;
            bin_class_reg <= bin_class_next;
            clr_cc_reg    <= clr_cc_next;
            clr_class_reg <= clr_class_next;
            out_reg       <= out_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
        end
    end

    // Flop-based file: the async reset must zero every counter at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                for (int k = 0; k < NUM_CC; k++)
                    ctr_reg[c][k] <= '0;
        end else if (clr_we) begin
            ctr_reg[clr_class_reg][clr_cc_reg] <= '0;
        end else if (train_we) begin
            ctr_reg[bus.train_class][bus.train_cc] <= train_sum;
        end
    end

    assign bus.train_ready          = train_ready;
    assign bus.busy                 = (state_reg != S_IDLE);
    assign bus.binarizing_class_hvs = valid_reg;
    assign bus.bin_cc               = bin_cc_reg;
    assign bus.nonbin_class_reg_out = out_reg;
    assign bus.bin_done             = done_reg;
endmodule

// File: tb/tb_class_accumulator.sv
// Directed bench for class_accumulator: training, saturation, clear priority,
// busy lockout, enable stall and reset abort.
module tb_class_accumulator;
    localparam int DIMS = 32;
    localparam int BW   = 4;
    localparam int NCC  = 16;
    localparam int NCL  = 4;
    localparam int WW   = DIMS * BW;

    localparam logic [WW-1:0] W_C1 = 128'h0000_0000_0000_0000_0000_0000_5555_5555;
    localparam logic [WW-1:0] W_C2 = 128'h0000_0000_0000_0000_0000_0000_0000_001F;
    localparam logic [WW-1:0] W_C3 = 128'h1111_0000_1111_0000_0000_0000_0000_0000;
    localparam logic [WW-1:0] W_C4 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    class_accumulator_if #(.DIMS_PER_CC(DIMS), .BITWIDTH_PER_DIM(BW),
                           .NUM_CC(NCC), .NUM_CLASSES(NCL)) bus ();

    class_accumulator #(.DIMS_PER_CC(DIMS), .BITWIDTH_PER_DIM(BW),
                        .NUM_CC(NCC), .NUM_CLASSES(NCL)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int nvec  = 0;
    int nfail = 0;

    logic [WW-1:0] cap_word [NCC];
    bit cap_seq_ok, cap_done_ok, cap_after_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [1:0] cls, input logic [3:0] cc, input logic [31:0] hv,
                         input int n, output int acc);
        acc = 0;
        bus.train_class = cls;
        bus.train_cc    = cc;
        bus.train_hv    = hv;
        bus.train_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            if (bus.train_ready === 1'b1) acc++;
            tick();
        end
        bus.train_valid = 1'b0;
        $display("train class=%0d cc=%0d hv=%h x%0d accepted=%0d", cls, cc, hv, n, acc);
    endtask

    task automatic run_binarize(input logic [1:0] cls);
        bus.bin_class = cls;
        bus.bin_start = 1'b1;
        tick();
        bus.bin_start = 1'b0;
        cap_seq_ok = 1'b1;
        for (int k = 0; k < NCC; k++) begin
            if (bus.binarizing_class_hvs !== 1'b1 || bus.bin_cc !== 4'(k) ||
                bus.bin_done !== 1'b0 || bus.busy !== 1'b1) cap_seq_ok = 1'b0;
            cap_word[k] = bus.nonbin_class_reg_out;
            tick();
        end
        cap_done_ok = (bus.bin_done === 1'b1) && (bus.binarizing_class_hvs === 1'b0) &&
                      (bus.nonbin_class_reg_out === '0) && (bus.busy === 1'b1);
        tick();
        cap_after_ok = (bus.bin_done === 1'b0) && (bus.busy === 1'b0);
        $display("binarize class=%0d seq_ok=%0d done_ok=%0d idle_ok=%0d",
                 cls, cap_seq_ok, cap_done_ok, cap_after_ok);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.en = 1'b1; bus.clr_start = 1'b0; bus.train_valid = 1'b0;
        bus.train_class = '0; bus.train_cc = '0; bus.train_hv = '0;
        bus.bin_start = 1'b0; bus.bin_class = '0;
        #12;
        nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.train_ready !== 1'b0) begin nfail++; $display("FAIL reset_train_ready: got %b want 0", bus.train_ready); end
        nvec++; if (bus.binarizing_class_hvs !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", bus.binarizing_class_hvs); end
        nvec++; if (bus.bin_done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b want 0", bus.bin_done); end
        nvec++; if (bus.bin_cc !== 4'd0) begin nfail++; $display("FAIL reset_bin_cc: got %0d want 0", bus.bin_cc); end
        nvec++; if (bus.nonbin_class_reg_out !== '0) begin nfail++; $display("FAIL reset_out: got %h want 0", bus.nonbin_class_reg_out); end
        tick();
        nrst = 1'b1;
        #1;
        nvec++; if (bus.train_ready !== 1'b1) begin nfail++; $display("FAIL idle_train_ready: got %b want 1", bus.train_ready); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_train_binarize();
        int acc;
        train(2'd1, 4'd3, 32'h0000_00FF, 5, acc);
        nvec++; if (acc != 5) begin nfail++; $display("FAIL train_accept: got %0d want 5", acc); end
        run_binarize(2'd1);
        nvec++; if (!cap_seq_ok) begin nfail++; $display("FAIL bin1_sequence: got bad want ok"); end
        nvec++; if (!cap_done_ok) begin nfail++; $display("FAIL bin1_done_at_17: got no want bin_done"); end
        nvec++; if (!cap_after_ok) begin nfail++; $display("FAIL bin1_back_idle: got busy want idle"); end
        for (int k = 0; k < NCC; k++) begin
            logic [WW-1:0] exp_w;
            exp_w = (k == 3) ? W_C1 : '0;
            nvec++;
            if (cap_word[k] !== exp_w) begin
                nfail++; $display("FAIL bin1_word%0d: got %h want %h", k, cap_word[k], exp_w);
            end
        end
    endtask

    task automatic test_saturation();
        int acc_a, acc_b;
        train(2'd2, 4'd0, 32'h0000_0003, 1, acc_a);
        train(2'd2, 4'd0, 32'h0000_0001, 19, acc_b);
        nvec++; if (acc_a + acc_b != 20) begin nfail++; $display("FAIL sat_accept: got %0d want 20", acc_a + acc_b); end
        run_binarize(2'd2);
        nvec++; if (!cap_seq_ok) begin nfail++; $display("FAIL sat_sequence: got bad want ok"); end
        nvec++; if (cap_word[0] !== W_C2) begin nfail++; $display("FAIL sat_word0: got %h want %h", cap_word[0], W_C2); end
        nvec++; if (cap_word[3] !== '0) begin nfail++; $display("FAIL sat_word3: got %h want 0", cap_word[3]); end
    endtask

    task automatic test_en_stall();
        bus.bin_class = 2'd1;
        bus.bin_start = 1'b1;
        tick();
        bus.bin_start = 1'b0;
        for (int j = 0; j < NCC + 3; j++) begin
            int exp_cc;
            logic [WW-1:0] exp_w;
            exp_cc = (j <= 6) ? j : ((j <= 9) ? 6 : j - 3);
            exp_w  = (exp_cc == 3) ? W_C1 : '0;
            if (j == 6) bus.en = 1'b0;
            if (j == 9) bus.en = 1'b1;
            nvec++;
            if (bus.binarizing_class_hvs !== 1'b1 || bus.bin_cc !== 4'(exp_cc)) begin
                nfail++; $display("FAIL stall_cc_cycle%0d: got valid=%b cc=%0d want valid=1 cc=%0d",
                                  j, bus.binarizing_class_hvs, bus.bin_cc, exp_cc);
            end
            nvec++;
            if (bus.nonbin_class_reg_out !== exp_w) begin
                nfail++; $display("FAIL stall_data_cycle%0d: got %h want %h", j, bus.nonbin_class_reg_out, exp_w);
            end
            tick();
        end
        nvec++; if (bus.bin_done !== 1'b1) begin nfail++; $display("FAIL stall_done: got %b want 1", bus.bin_done); end
        tick();
        $display("test_en_stall done");
    endtask

    task automatic test_train_during_bin();
        int acc;
        bit ready_seen, seq_ok;
        train(2'd3, 4'd5, 32'hF0F0_0000, 1, acc);
        bus.bin_class = 2'd3;
        bus.bin_start = 1'b1;
        tick();
        bus.bin_start   = 1'b0;
        bus.train_class = 2'd3; bus.train_cc = 4'd5; bus.train_hv = '1; bus.train_valid = 1'b1;
        ready_seen = 1'b0;
        seq_ok     = 1'b1;
        for (int k = 0; k < NCC; k++) begin
            if (k == 4) begin bus.bin_start = 1'b1; bus.bin_class = 2'd0; end
            #1;
            if (bus.train_ready !== 1'b0) ready_seen = 1'b1;
            if (bus.binarizing_class_hvs !== 1'b1 || bus.bin_cc !== 4'(k)) seq_ok = 1'b0;
            cap_word[k] = bus.nonbin_class_reg_out;
            tick();
            bus.bin_start = 1'b0;
        end
        #1;
        if (bus.train_ready !== 1'b0) ready_seen = 1'b1;
        nvec++; if (bus.bin_done !== 1'b1) begin nfail++; $display("FAIL lock_done: got %b want 1", bus.bin_done); end
        bus.train_valid = 1'b0;
        tick();
        nvec++; if (ready_seen) begin nfail++; $display("FAIL lock_train_ready: got 1 want 0 while busy"); end
        nvec++; if (!seq_ok) begin nfail++; $display("FAIL lock_no_restart: got restarted want steady"); end
        nvec++; if (cap_word[5] !== W_C3) begin nfail++; $display("FAIL lock_word5: got %h want %h", cap_word[5], W_C3); end
        run_binarize(2'd3);
        nvec++; if (cap_word[5] !== W_C3) begin nfail++; $display("FAIL lock_unchanged: got %h want %h", cap_word[5], W_C3); end
    endtask

    task automatic test_clear_priority();
        int busy_cnt;
        bit bad;
        bus.clr_start = 1'b1;
        bus.bin_start = 1'b1;
        bus.bin_class = 2'd1;
        #1;
        nvec++; if (bus.train_ready !== 1'b0) begin nfail++; $display("FAIL clr_train_ready: got %b want 0", bus.train_ready); end
        tick();
        bus.clr_start = 1'b0;
        bus.bin_start = 1'b0;
        busy_cnt = 0;
        bad = 1'b0;
        while (bus.busy === 1'b1 && busy_cnt < 200) begin
            if (bus.binarizing_class_hvs !== 1'b0 || bus.bin_done !== 1'b0) bad = 1'b1;
            busy_cnt++;
            tick();
        end
        nvec++; if (busy_cnt != NCC * NCL) begin nfail++; $display("FAIL clr_busy_len: got %0d want %0d", busy_cnt, NCC * NCL); end
        nvec++; if (bad) begin nfail++; $display("FAIL clr_no_bin: got bin activity want none"); end
        run_binarize(2'd1);
        for (int k = 0; k < NCC; k++) begin
            nvec++;
            if (cap_word[k] !== '0) begin nfail++; $display("FAIL clr_c1_word%0d: got %h want 0", k, cap_word[k]); end
        end
        run_binarize(2'd2);
        nvec++; if (cap_word[0] !== '0) begin nfail++; $display("FAIL clr_c2_word0: got %h want 0", cap_word[0]); end
        run_binarize(2'd3);
        nvec++; if (cap_word[5] !== '0) begin nfail++; $display("FAIL clr_c3_word5: got %h want 0", cap_word[5]); end
    endtask

    task automatic test_reset_mid_clear();
        int acc;
        train(2'd3, 4'd7, 32'hFFFF_FFFF, 2, acc);
        run_binarize(2'd3);
        nvec++; if (cap_word[7] !== W_C4) begin nfail++; $display("FAIL pre_rst_word7: got %h want %h", cap_word[7], W_C4); end
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        repeat (10) tick();
        nvec++; if (bus.busy !== 1'b1) begin nfail++; $display("FAIL midclr_busy: got %b want 1", bus.busy); end
        nrst = 1'b0;
        #1;
        nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL rstclr_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.train_ready !== 1'b0) begin nfail++; $display("FAIL rstclr_ready: got %b want 0", bus.train_ready); end
        nvec++; if (bus.bin_done !== 1'b0 || bus.binarizing_class_hvs !== 1'b0) begin
            nfail++; $display("FAIL rstclr_flags: got done=%b valid=%b want 0 0", bus.bin_done, bus.binarizing_class_hvs);
        end
        nvec++; if (bus.bin_cc !== 4'd0 || bus.nonbin_class_reg_out !== '0) begin
            nfail++; $display("FAIL rstclr_data: got cc=%0d out=%h want 0", bus.bin_cc, bus.nonbin_class_reg_out);
        end
        tick();
        tick();
        nrst = 1'b1;
        tick();
        nvec++; if (bus.busy !== 1'b0 || bus.bin_done !== 1'b0) begin
            nfail++; $display("FAIL rstclr_after: got busy=%b done=%b want 0 0", bus.busy, bus.bin_done);
        end
        run_binarize(2'd3);
        nvec++; if (!cap_seq_ok || !cap_done_ok) begin nfail++; $display("FAIL rstclr_bin_seq: got bad want ok"); end
        nvec++; if (cap_word[7] !== '0) begin nfail++; $display("FAIL rstclr_word7: got %h want 0", cap_word[7]); end
    endtask

    initial begin
        test_reset();
        test_train_binarize();
        test_saturation();
        test_en_stall();
        test_train_during_bin();
        test_clear_priority();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
